// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states, parity
// modes, majority vote and the legal parameter envelope.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // The oversample rate must be even so that the first decision lands on a whole tick.
  function automatic bit cfg_legal(input int data_bits, input int parity,
                                   input int stop_bits, input int oversample);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (oversample >= 8) && (oversample <= 32) && ((oversample % 2) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser on RXD and a 3-sample majority vote
// taken over the current tick and the two ticks before it.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic RXD,
  input  logic BAUD_EN,
  output logic rxd_sync,
  output logic vote
);

  logic [1:0] sync_ff;
  logic [1:0] hist;
  logic [2:0] window;

  // Both stages reset to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], RXD};
    end
  end

  assign rxd_sync = sync_ff[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist <= 2'b11;
    end else if (BAUD_EN) begin
      hist <= {hist[0], rxd_sync};
    end
  end

  assign window = {hist, rxd_sync};
  assign vote   = maj3(window);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, bit timing, parity/stop/break checks
// and a valid/ready output register with overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RXD,
  input  logic                 BAUD_EN,
  input  logic                 RX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 FRM_ERR,
  output logic                 PARITY_ERR,
  output logic                 BREAK_DET,
  output logic                 OVERRUN_ERR,
  output logic                 BUSY
);

  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_C    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] OS_C      = CW'(OVERSAMPLE);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (!cfg_legal(DATA_BITS, PARITY, STOP_BITS, OVERSAMPLE)) begin : g_cfg_check
    $error("uart_rx_param: illegal DATA_BITS/PARITY/STOP_BITS/OVERSAMPLE combination");
  end

  logic rxd_sync;
  logic vote;

  uart_rx_sampler u_sampler (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RXD      (RXD),
    .BAUD_EN  (BAUD_EN),
    .rxd_sync (rxd_sync),
    .vote     (vote)
  );

  rx_state_t            state, state_nxt;
  logic [CW-1:0]        tick_cnt, tick_nxt, cnt_inc;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 par_pend, par_nxt;
  logic                 frm_pend, frm_nxt;
  logic                 seen_one, seen_nxt;
  logic                 decide;
  logic                 stop_frm, stop_seen;
  logic                 frame_done;
  logic                 done_brk;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_pend  <= 1'b0;
      frm_pend  <= 1'b0;
      seen_one  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      par_pend  <= par_nxt;
      frm_pend  <= frm_nxt;
      seen_one  <= seen_nxt;
    end
  end

  // seen_one tracks any 1 vote after the start bit; its absence at frame end means break.
  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift_reg;
    par_nxt    = par_pend;
    frm_nxt    = frm_pend;
    seen_nxt   = seen_one;
    frame_done = 1'b0;
    done_brk   = 1'b0;
    cnt_inc    = tick_cnt + CW'(1);
    decide     = (state == START) ? (cnt_inc == HALF_C) : (cnt_inc == OS_C);
    stop_frm   = frm_pend | ~vote;
    stop_seen  = seen_one | vote;

    if (BAUD_EN) begin
      if (state != IDLE) begin
        tick_nxt = decide ? '0 : cnt_inc;
      end
      unique case (state)
        IDLE: begin
          if (!rxd_sync) begin
            state_nxt = START;
            tick_nxt  = '0;
            bit_nxt   = '0;
            shift_nxt = '0;
            par_nxt   = 1'b0;
            frm_nxt   = 1'b0;
            seen_nxt  = 1'b0;
          end
        end
        START: begin
          if (decide) begin
            state_nxt = vote ? IDLE : DATA;
          end
        end
        DATA: begin
          if (decide) begin
            shift_nxt = {vote, shift_reg[DATA_BITS-1:1]};
            seen_nxt  = stop_seen;
            if (bit_cnt == DATA_LAST) begin
              bit_nxt   = '0;
              state_nxt = (PARITY == PAR_NONE) ? STOP : PAR;
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end
        end
        PAR: begin
          if (decide) begin
            par_nxt   = ((^shift_reg) ^ vote) != (PARITY == PAR_ODD);
            seen_nxt  = stop_seen;
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (decide) begin
            frm_nxt  = stop_frm;
            seen_nxt = stop_seen;
            if (bit_cnt == STOP_LAST) begin
              frame_done = 1'b1;
              done_brk   = ~stop_seen;
              state_nxt  = IDLE;
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A completed frame is dropped, not queued, when the previous word is still unaccepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RX_DATA     <= '0;
      RX_VALID    <= 1'b0;
      FRM_ERR     <= 1'b0;
      PARITY_ERR  <= 1'b0;
      BREAK_DET   <= 1'b0;
      OVERRUN_ERR <= 1'b0;
    end else begin
      OVERRUN_ERR <= 1'b0;
      if (frame_done) begin
        if (!RX_VALID || RX_READY) begin
          RX_DATA    <= done_brk ? '0 : shift_reg;
          RX_VALID   <= 1'b1;
          FRM_ERR    <= stop_frm;
          PARITY_ERR <= par_pend;
          BREAK_DET  <= done_brk;
        end else begin
          OVERRUN_ERR <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID   <= 1'b0;
        FRM_ERR    <= 1'b0;
        PARITY_ERR <= 1'b0;
        BREAK_DET  <= 1'b0;
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus randomized bench for uart_rx_param using three frame formats
// (8N1, 7E1, 8N2) checked against a bit-level frame model.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int OS      = 16;
  localparam int BIT_CYC = 2 * OS;

  logic CLK, RST_N, BAUD_EN;
  logic rxd0, rxd1, rxd2, rdy0, rdy1, rdy2;
  logic [7:0] data0;
  logic [6:0] data1;
  logic [7:0] data2;
  logic valid0, frm0, perr0, brk0, ovr0, busy0;
  logic valid1, frm1, perr1, brk1, ovr1, busy1;
  logic valid2, frm2, perr2, brk2, ovr2, busy2;

  int checks = 0;
  int errors = 0;
  int vcyc   = 0;
  int ovr    = 0;
  logic [11:0] q0[$];
  logic [11:0] expq[$];

  uart_rx_param #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .OVERSAMPLE(OS)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .RXD(rxd0), .BAUD_EN(BAUD_EN), .RX_READY(rdy0),
    .RX_DATA(data0), .RX_VALID(valid0), .FRM_ERR(frm0), .PARITY_ERR(perr0),
    .BREAK_DET(brk0), .OVERRUN_ERR(ovr0), .BUSY(busy0));

  uart_rx_param #(.DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1), .OVERSAMPLE(OS)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .RXD(rxd1), .BAUD_EN(BAUD_EN), .RX_READY(rdy1),
    .RX_DATA(data1), .RX_VALID(valid1), .FRM_ERR(frm1), .PARITY_ERR(perr1),
    .BREAK_DET(brk1), .OVERRUN_ERR(ovr1), .BUSY(busy1));

  uart_rx_param #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .OVERSAMPLE(OS)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .RXD(rxd2), .BAUD_EN(BAUD_EN), .RX_READY(rdy2),
    .RX_DATA(data2), .RX_VALID(valid2), .FRM_ERR(frm2), .PARITY_ERR(perr2),
    .BREAK_DET(brk2), .OVERRUN_ERR(ovr2), .BUSY(busy2));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    BAUD_EN = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      BAUD_EN = ~BAUD_EN;
    end
  end

  function automatic logic [11:0] obs0();
    return {brk0, perr0, frm0, 1'b0, data0};
  endfunction

  function automatic logic [11:0] obs1();
    return {brk1, perr1, frm1, 2'b00, data1};
  endfunction

  function automatic logic [11:0] obs2();
    return {brk2, perr2, frm2, 1'b0, data2};
  endfunction

  // Accepted words and handshake activity of the 8N1 receiver.
  always @(negedge CLK) begin
    if (valid0 && rdy0) q0.push_back(obs0());
    if (valid0) vcyc++;
    if (ovr0) ovr++;
  end

  function automatic logic good_par(input int par, input logic [8:0] data, input int dbits);
    logic x;
    x = 1'b0;
    for (int i = 0; i < dbits; i++) x = x ^ data[i];
    return (par == PAR_ODD) ? ~x : x;
  endfunction

  // Expected {break, parity_err, frame_err, data} for a frame with the given line bits.
  function automatic logic [11:0] model(input int dbits, input int par, input logic [8:0] data,
                                        input logic pbit, input logic [1:0] stops, input int nstop);
    logic [8:0] d;
    logic frm, perr, allz;
    d = '0;
    for (int i = 0; i < dbits; i++) d[i] = data[i];
    frm  = !stops[0] || (nstop == 2 && !stops[1]);
    perr = (par != PAR_NONE) && (((^d) ^ pbit) != (par == PAR_ODD));
    allz = (d == 0) && (par == PAR_NONE || !pbit) && !stops[0] && (nstop == 1 || !stops[1]);
    if (allz) begin
      d   = '0;
      frm = 1'b1;
    end
    return {allz, perr, frm, d};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_line(input int idx, input logic v);
    case (idx)
      0:       rxd0 = v;
      1:       rxd1 = v;
      default: rxd2 = v;
    endcase
  endtask

  task automatic apply_stimulus(input int idx, input int dbits, input int par, input logic [8:0] data,
                                input logic pbit, input logic [1:0] stops, input int nstop);
    set_line(idx, 1'b0);
    step(BIT_CYC);
    for (int i = 0; i < dbits; i++) begin
      set_line(idx, data[i]);
      step(BIT_CYC);
    end
    if (par != PAR_NONE) begin
      set_line(idx, pbit);
      step(BIT_CYC);
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(idx, stops[s]);
      step(BIT_CYC);
    end
    set_line(idx, 1'b1);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [8:0]  d;
    logic        pb;
    logic [1:0]  st;
    logic [11:0] e;
    int          gap, base;

    RST_N = 1'b1;
    rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b0; rdy2 = 1'b0;
    #2 RST_N = 1'b0;
    step(4);
    $display("[TB] reset state");
    check_output("rst_data0", 32'(data0), 0);
    check_output("rst_valid0", 32'(valid0), 0);
    check_output("rst_flags0", 32'({frm0, perr0, brk0}), 0);
    check_output("rst_ovr0", 32'(ovr0), 0);
    check_output("rst_busy0", 32'(busy0), 0);
    check_output("rst_valid12", 32'({valid1, valid2}), 0);
    RST_N = 1'b1;
    step(2 * BIT_CYC);

    $display("[TB] 8N1 frame 0xA5");
    base = vcyc;
    apply_stimulus(0, 8, PAR_NONE, 9'h0A5, 1'b0, 2'b11, 1);
    step(BIT_CYC);
    check_output("a5_count", 32'(q0.size()), 1);
    e = (q0.size() > 0) ? q0.pop_front() : 12'hfff;
    check_output("a5_word", 32'(e), 32'(model(8, PAR_NONE, 9'h0A5, 1'b0, 2'b11, 1)));
    check_output("a5_valid_cycles", 32'(vcyc - base), 1);
    check_output("a5_no_overrun", 32'(ovr), 0);

    $display("[TB] false start and glitch rejection");
    set_line(0, 1'b0);
    step(8);
    set_line(0, 1'b1);
    check_output("false_start_busy", 32'(busy0), 1);
    step(BIT_CYC);
    check_output("false_start_idle", 32'(busy0), 0);
    check_output("false_start_noword", 32'(q0.size()), 0);
    set_line(0, 1'b0);
    step(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        step(14);
        set_line(0, 1'b1);
        step(2);
        set_line(0, 1'b0);
        step(16);
      end else begin
        step(BIT_CYC);
      end
    end
    set_line(0, 1'b1);
    step(2 * BIT_CYC);
    check_output("glitch_count", 32'(q0.size()), 1);
    e = (q0.size() > 0) ? q0.pop_front() : 12'hfff;
    check_output("glitch_word", 32'(e), 32'(model(8, PAR_NONE, 9'h000, 1'b0, 2'b11, 1)));

    $display("[TB] 7E1 bad parity and 8N2 bad second stop");
    apply_stimulus(1, 7, PAR_EVEN, 9'h041, 1'b1, 2'b11, 1);
    step(BIT_CYC);
    check_output("7e1_valid", 32'(valid1), 1);
    check_output("7e1_word", 32'(obs1()), 32'(model(7, PAR_EVEN, 9'h041, 1'b1, 2'b11, 1)));
    rdy1 = 1'b1; step(1); rdy1 = 1'b0; step(1);
    check_output("7e1_accept", 32'(valid1), 0);
    apply_stimulus(2, 8, PAR_NONE, 9'h096, 1'b0, 2'b01, 2);
    step(BIT_CYC);
    check_output("8n2_valid", 32'(valid2), 1);
    check_output("8n2_word", 32'(obs2()), 32'(model(8, PAR_NONE, 9'h096, 1'b0, 2'b01, 2)));

    $display("[TB] random 7E1 frames");
    for (int k = 0; k < 8; k++) begin
      d  = 9'($urandom_range(0, 127));
      pb = ($urandom_range(0, 1) == 1) ? good_par(PAR_EVEN, d, 7) : ~good_par(PAR_EVEN, d, 7);
      st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      apply_stimulus(1, 7, PAR_EVEN, d, pb, st, 1);
      step(BIT_CYC);
      check_output("r7e1_valid", 32'(valid1), 1);
      check_output("r7e1_word", 32'(obs1()), 32'(model(7, PAR_EVEN, d, pb, st, 1)));
      rdy1 = 1'b1; step(1); rdy1 = 1'b0; step(1);
    end

    $display("[TB] overrun");
    rdy0 = 1'b0;
    q0.delete();
    base = ovr;
    apply_stimulus(0, 8, PAR_NONE, 9'h011, 1'b0, 2'b11, 1);
    apply_stimulus(0, 8, PAR_NONE, 9'h022, 1'b0, 2'b11, 1);
    step(BIT_CYC);
    check_output("ovr_pulses", 32'(ovr - base), 1);
    check_output("ovr_hold_valid", 32'(valid0), 1);
    check_output("ovr_hold_word", 32'(obs0()), 32'(model(8, PAR_NONE, 9'h011, 1'b0, 2'b11, 1)));
    rdy0 = 1'b1;
    step(2);
    check_output("ovr_accept", 32'(valid0), 0);
    check_output("ovr_accept_count", 32'(q0.size()), 1);
    e = (q0.size() > 0) ? q0.pop_front() : 12'hfff;
    check_output("ovr_accept_word", 32'(e), 32'(model(8, PAR_NONE, 9'h011, 1'b0, 2'b11, 1)));

    // The line stays low past the break frame, so a trailing frame may follow; only the first matters.
    $display("[TB] break");
    set_line(0, 1'b0);
    step(12 * BIT_CYC);
    set_line(0, 1'b1);
    step(10 * BIT_CYC);
    check_output("break_seen", 32'(q0.size() > 0), 1);
    e = (q0.size() > 0) ? q0[0] : 12'hfff;
    check_output("break_word", 32'(e), 32'(model(8, PAR_NONE, 9'h000, 1'b0, 2'b00, 1)));
    q0.delete();
    apply_stimulus(0, 8, PAR_NONE, 9'h05A, 1'b0, 2'b11, 1);
    step(BIT_CYC);
    check_output("post_break_count", 32'(q0.size()), 1);
    e = (q0.size() > 0) ? q0.pop_front() : 12'hfff;
    check_output("post_break_word", 32'(e), 32'(model(8, PAR_NONE, 9'h05A, 1'b0, 2'b11, 1)));

    $display("[TB] reset mid-frame");
    rdy0 = 1'b0;
    apply_stimulus(0, 8, PAR_NONE, 9'h077, 1'b0, 2'b11, 1);
    step(BIT_CYC);
    check_output("pre_rst_valid", 32'(valid0), 1);
    set_line(0, 1'b0);
    step(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      set_line(0, i[0]);
      step(BIT_CYC);
    end
    set_line(0, 1'b0);
    step(16);
    check_output("pre_rst_busy", 32'(busy0), 1);
    RST_N = 1'b0;
    #1;
    check_output("rst_mid_valid", 32'(valid0), 0);
    check_output("rst_mid_word", 32'(obs0()), 0);
    check_output("rst_mid_busy", 32'(busy0), 0);
    set_line(0, 1'b1);
    step(4);
    RST_N = 1'b1;
    rdy0 = 1'b1;
    step(2 * BIT_CYC);
    check_output("rst_no_word", 32'(q0.size()), 0);
    apply_stimulus(0, 8, PAR_NONE, 9'h03C, 1'b0, 2'b11, 1);
    step(BIT_CYC);
    check_output("post_rst_count", 32'(q0.size()), 1);
    e = (q0.size() > 0) ? q0.pop_front() : 12'hfff;
    check_output("post_rst_word", 32'(e), 32'(model(8, PAR_NONE, 9'h03C, 1'b0, 2'b11, 1)));

    // A frame with a 0 stop bit needs an idle bit after it before the next start.
    $display("[TB] random 8N1 stream");
    q0.delete();
    expq.delete();
    base = ovr;
    for (int k = 0; k < 24; k++) begin
      d   = 9'($urandom_range(0, 255));
      gap = $urandom_range(0, 2);
      st  = (gap > 0 && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      apply_stimulus(0, 8, PAR_NONE, d, 1'b0, st, 1);
      expq.push_back(model(8, PAR_NONE, d, 1'b0, st, 1));
      step(gap * BIT_CYC);
    end
    step(2 * BIT_CYC);
    check_output("stream_count", 32'(q0.size()), 32'(expq.size()));
    for (int k = 0; k < expq.size(); k++) begin
      e = (k < q0.size()) ? q0[k] : 12'hfff;
      check_output("stream_word", 32'(e), 32'(expq[k]));
    end
    check_output("stream_no_overrun", 32'(ovr - base), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
